isu_rc_arbiter: RTL and testbench
=================================

Name: isu_rc_arbiter

Overview:
- Shares one SRAM-controller request port (d_rc_*) among NUM_REQ issue queues; each queue is an lsq/refill-buffer pair.
- Arbitration is round-robin. A request is eligible only if its xbar channel holds a return credit.
- Per-channel credit counters are decremented on grant and incremented on xbar credit return.
- The winner is registered into a single output stage; downstream sees 1-cycle latency.

Parameters:
NUM_REQ, 4, number of requesting issue queues (2..8)
SET_W, 8, set index width
WAY_W, 3, way index width
WBUF_W, 4, write-buffer id width
ROB_W, 5, rob id width (passed through)
CRDT_INIT, 16, credits per channel after reset (1..2**ROB_W)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, synchronous, active-low
req_valid  in  NUM_REQ  per-queue request valid
req_ready  out  NUM_REQ  per-queue accept
req_channel_1hot_id  in  NUM_REQ*3  target xbar channel, one-hot
req_rob_id  in  NUM_REQ*ROB_W  rob id
req_op  in  NUM_REQ*3  cache op (mpc_types encoding)
req_set  in  NUM_REQ*SET_W  set
req_way  in  NUM_REQ*WAY_W  way
req_wbuf_id  in  NUM_REQ*WBUF_W  write-buffer id
req_refill_data  in  NUM_REQ*128  refill line
xbar_crdt_rtn_valid  in  3  one credit returned per set bit, per channel
d_rc_valid  out  1  registered request valid
d_rc_ready  in  1  SRAM controller accept
d_rc_req_id  out  $clog2(NUM_REQ)  index of the granted queue
d_rc_channel_1hot_id, d_rc_rob_id, d_rc_op, d_rc_set, d_rc_way, d_rc_wbuf_id, d_rc_refill_data  out  as req  registered payload
crdt_avail  out  3  per-channel credit count non-zero

Behaviour:
- Reset (rst_n=0 at posedge):
  - d_rc_valid=0 and all d_rc_* payload=0.
  - rr_ptr=0; crdt_cnt[c]=CRDT_INIT; crdt_avail=3'b111.
  - req_ready is combinational and is 0 while d_rc_valid=1 and d_rc_ready=0.
- Credit counters: width $clog2(CRDT_INIT+1).
- Eligibility:
  - eligible[i] = req_valid[i] & $onehot(ch[i]) & |(ch[i] & crdt_avail).
  - A zero or multi-hot channel is never eligible; a simulation assertion fires.
- Pick: the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Load condition: load = |eligible & (~d_rc_valid | d_rc_ready).
  - Pass-through in the same cycle as a downstream pop is allowed: full throughput, 1 request/cycle.
- On load:
  - req_ready[winner]=1 (combinational, one-hot); all other bits are 0.
  - The payload and winner index are registered; d_rc_valid=1 next cycle.
  - rr_ptr <= (winner+1) mod NUM_REQ. rr_ptr is unchanged when there is no load.
- Output hold: d_rc_valid & ~d_rc_ready holds the payload stable. Otherwise d_rc_valid <= load.
- Credit update per channel c, each cycle: cnt <= cnt - (load & ch_winner[c]) + xbar_crdt_rtn_valid[c].
  - Simultaneous consume and return leaves the count unchanged.
  - Credits are consumed at load, not at the d_rc handshake.
  - A return at cnt==CRDT_INIT saturates and fires an assertion.
  - Consume at cnt==0 is impossible by eligibility.
- crdt_avail is registered (cnt!=0), so there is no combinational path from xbar_crdt_rtn_valid to req_ready.
- Reset mid-operation:
  - The output request is dropped regardless of d_rc_ready.
  - Outstanding credits are forfeited; counters are reloaded to CRDT_INIT. Upstream blocks reset together.

Optional Feature:
ISU_ARB_REFILL_PRIO_EN:
- Defined: when any eligible request has op CACHE_OP_LOAD_REFILL or CACHE_OP_STORE_REFILL, the pick is restricted to those requests, using the same rr_ptr scan and update. Non-refill requests may starve while refills persist.
- Undefined: all ops are arbitrated equally.

Decomposition:
- Add is_refill(op) to mpc_types beside is_load/is_store.
- Add the constant ISU_NUM_CHANNEL=3 to mpc_types.
- One sub-module, rr_picker: combinational inputs (mask[NUM_REQ], ptr) -> (onehot grant, index, any). It is reused for the optional refill mask.

Test Plan:
- Reset, then all 4 queues valid on channel 3'b001 with d_rc_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; d_rc_valid from cycle 1.
- CRDT_INIT=2, queue0 channel 3'b010 continuously valid, no returns -> exactly 2 grants, then crdt_avail[1]=0 and req_ready stays 0. One xbar_crdt_rtn_valid[1] pulse -> exactly 1 further grant, 2 cycles later.
- d_rc_ready=0 for 5 cycles with queue2 valid -> payload stable; req_ready=0 after the first load; counters change only once.
- Consume and return on the same channel in the same cycle at cnt=1 -> cnt stays 1; crdt_avail stays 1.
- With ISU_ARB_REFILL_PRIO_EN: queue0 STORE, queue3 LOAD_REFILL, rr_ptr=0 -> queue3 wins first; without the macro -> queue0 wins.
- Assert rst_n=0 while d_rc_valid=1 and d_rc_ready=0 -> next cycle d_rc_valid=0, all crdt_cnt=CRDT_INIT, rr_ptr=0.

Source files
------------

// File: rtl/isu_rc_arbiter_pkg.sv
// Shared cache-op encoding and channel constants for the issue-queue to SRAM-controller arbiter.
package isu_rc_arbiter_pkg;

  localparam int unsigned ISU_NUM_CHANNEL = 3;

  typedef enum logic [2:0] {
    CACHE_OP_LOAD         = 3'd0,
    CACHE_OP_STORE        = 3'd1,
    CACHE_OP_LOAD_REFILL  = 3'd2,
    CACHE_OP_STORE_REFILL = 3'd3,
    CACHE_OP_EVICT        = 3'd4,
    CACHE_OP_FLUSH        = 3'd5
  } cache_op_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op == CACHE_OP_LOAD) || (op == CACHE_OP_LOAD_REFILL);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == CACHE_OP_STORE) || (op == CACHE_OP_STORE_REFILL);
  endfunction

  function automatic logic is_refill(input logic [2:0] op);
    return (op == CACHE_OP_LOAD_REFILL) || (op == CACHE_OP_STORE_REFILL);
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/isu_rc_arbiter_rr_picker.sv
// Combinational round-robin picker: first set mask bit scanning from ptr upward, modulo N.
module isu_rc_arbiter_rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      automatic int j = (int'(ptr) + k) % int'(N);
      if (!any && mask[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/isu_rc_arbiter.sv
// Credit-gated round-robin arbiter onto the single d_rc request port with one output register stage.
// Define ISU_ARB_REFILL_PRIO_EN to give refill ops strict priority over other eligible requests.
module isu_rc_arbiter
  import isu_rc_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SET_W     = 8,
  parameter int unsigned WAY_W     = 3,
  parameter int unsigned WBUF_W    = 4,
  parameter int unsigned ROB_W     = 5,
  parameter int unsigned CRDT_INIT = 16,
  localparam int unsigned IdxW = $clog2(NUM_REQ),
  localparam int unsigned NC   = ISU_NUM_CHANNEL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*NC-1:0]   req_channel_1hot_id,
  input  logic [NUM_REQ*ROB_W-1:0] req_rob_id,
  input  logic [NUM_REQ*3-1:0]    req_op,
  input  logic [NUM_REQ*SET_W-1:0] req_set,
  input  logic [NUM_REQ*WAY_W-1:0] req_way,
  input  logic [NUM_REQ*WBUF_W-1:0] req_wbuf_id,
  input  logic [NUM_REQ*128-1:0]  req_refill_data,
  input  logic [NC-1:0]           xbar_crdt_rtn_valid,
  output logic                    d_rc_valid,
  input  logic                    d_rc_ready,
  output logic [IdxW-1:0]         d_rc_req_id,
  output logic [NC-1:0]           d_rc_channel_1hot_id,
  output logic [ROB_W-1:0]        d_rc_rob_id,
  output logic [2:0]              d_rc_op,
  output logic [SET_W-1:0]        d_rc_set,
  output logic [WAY_W-1:0]        d_rc_way,
  output logic [WBUF_W-1:0]       d_rc_wbuf_id,
  output logic [127:0]            d_rc_refill_data,
  output logic [NC-1:0]           crdt_avail
);

  localparam int unsigned CntW = $clog2(CRDT_INIT + 1);

  logic [NC-1:0]      ch [NUM_REQ];
  logic [2:0]         op [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;

  logic [IdxW-1:0]    rr_ptr_q;
  logic [CntW-1:0]    crdt_cnt_q [NC];
  logic [CntW-1:0]    crdt_cnt_d [NC];
  logic [NC-1:0]      crdt_avail_q, crdt_avail_d, crdt_cons;

  logic [NUM_REQ-1:0] base_grant, win_grant;
  logic [IdxW-1:0]    base_idx, win_idx;
  logic               base_any, load;

  logic [NC-1:0]      sel_ch;
  logic [ROB_W-1:0]   sel_rob;
  logic [2:0]         sel_op;
  logic [SET_W-1:0]   sel_set;
  logic [WAY_W-1:0]   sel_way;
  logic [WBUF_W-1:0]  sel_wbuf;
  logic [127:0]       sel_data;

  logic               d_rc_valid_q;
  logic [IdxW-1:0]    d_rc_req_id_q;
  logic [NC-1:0]      d_rc_ch_q;
  logic [ROB_W-1:0]   d_rc_rob_q;
  logic [2:0]         d_rc_op_q;
  logic [SET_W-1:0]   d_rc_set_q;
  logic [WAY_W-1:0]   d_rc_way_q;
  logic [WBUF_W-1:0]  d_rc_wbuf_q;
  logic [127:0]       d_rc_data_q;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      ch[i]       = req_channel_1hot_id[i*NC +: NC];
      op[i]       = req_op[i*3 +: 3];
      eligible[i] = req_valid[i] & is_onehot3(ch[i]) & |(ch[i] & crdt_avail_q);
    end
  end

  isu_rc_arbiter_rr_picker #(.N(NUM_REQ)) u_base_pick (
    .mask  (eligible),
    .ptr   (rr_ptr_q),
    .grant (base_grant),
    .idx   (base_idx),
    .any   (base_any)
  );

`ifdef ISU_ARB_REFILL_PRIO_EN
  logic [NUM_REQ-1:0] refill_mask, refill_grant;
  logic [IdxW-1:0]    refill_idx;
  logic               refill_any;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      refill_mask[i] = eligible[i] & is_refill(op[i]);
    end
  end

  isu_rc_arbiter_rr_picker #(.N(NUM_REQ)) u_refill_pick (
    .mask  (refill_mask),
    .ptr   (rr_ptr_q),
    .grant (refill_grant),
    .idx   (refill_idx),
    .any   (refill_any)
  );

  assign win_grant = refill_any ? refill_grant : base_grant;
  assign win_idx   = refill_any ? refill_idx   : base_idx;
`else
  assign win_grant = base_grant;
  assign win_idx   = base_idx;
`endif

  // Pass-through allowed: a pop this cycle frees the stage for a new load.
  assign load      = base_any & (~d_rc_valid_q | d_rc_ready);
  assign req_ready = load ? win_grant : '0;

  always_comb begin
    sel_ch   = '0;
    sel_rob  = '0;
    sel_op   = '0;
    sel_set  = '0;
    sel_way  = '0;
    sel_wbuf = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_grant[i]) begin
        sel_ch   |= ch[i];
        sel_rob  |= req_rob_id[i*ROB_W +: ROB_W];
        sel_op   |= op[i];
        sel_set  |= req_set[i*SET_W +: SET_W];
        sel_way  |= req_way[i*WAY_W +: WAY_W];
        sel_wbuf |= req_wbuf_id[i*WBUF_W +: WBUF_W];
        sel_data |= req_refill_data[i*128 +: 128];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NC); c++) begin
      crdt_cons[c]  = load & sel_ch[c];
      crdt_cnt_d[c] = crdt_cnt_q[c];
      if (crdt_cons[c] && !xbar_crdt_rtn_valid[c]) begin
        crdt_cnt_d[c] = crdt_cnt_q[c] - CntW'(1);
      end else if (!crdt_cons[c] && xbar_crdt_rtn_valid[c] &&
                   crdt_cnt_q[c] != CntW'(CRDT_INIT)) begin
        crdt_cnt_d[c] = crdt_cnt_q[c] + CntW'(1);
      end
      crdt_avail_d[c] = (crdt_cnt_d[c] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      crdt_avail_q  <= '1;
      for (int c = 0; c < int'(NC); c++) crdt_cnt_q[c] <= CntW'(CRDT_INIT);
      d_rc_valid_q  <= 1'b0;
      d_rc_req_id_q <= '0;
      d_rc_ch_q     <= '0;
      d_rc_rob_q    <= '0;
      d_rc_op_q     <= '0;
      d_rc_set_q    <= '0;
      d_rc_way_q    <= '0;
      d_rc_wbuf_q   <= '0;
      d_rc_data_q   <= '0;
    end else begin
      crdt_avail_q <= crdt_avail_d;
      for (int c = 0; c < int'(NC); c++) crdt_cnt_q[c] <= crdt_cnt_d[c];
      if (load) begin
        rr_ptr_q      <= (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        d_rc_valid_q  <= 1'b1;
        d_rc_req_id_q <= win_idx;
        d_rc_ch_q     <= sel_ch;
        d_rc_rob_q    <= sel_rob;
        d_rc_op_q     <= sel_op;
        d_rc_set_q    <= sel_set;
        d_rc_way_q    <= sel_way;
        d_rc_wbuf_q   <= sel_wbuf;
        d_rc_data_q   <= sel_data;
      end else if (!(d_rc_valid_q && !d_rc_ready)) begin
        d_rc_valid_q <= 1'b0;
      end
    end
  end

  // Malformed channel ids and credit over-return are upstream protocol bugs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        assert (!req_valid[i] || is_onehot3(ch[i]));
      end
      for (int c = 0; c < int'(NC); c++) begin
        assert (!(xbar_crdt_rtn_valid[c] && !crdt_cons[c] &&
                  crdt_cnt_q[c] == CntW'(CRDT_INIT)));
      end
    end
  end

  assign d_rc_valid           = d_rc_valid_q;
  assign d_rc_req_id          = d_rc_req_id_q;
  assign d_rc_channel_1hot_id = d_rc_ch_q;
  assign d_rc_rob_id          = d_rc_rob_q;
  assign d_rc_op              = d_rc_op_q;
  assign d_rc_set             = d_rc_set_q;
  assign d_rc_way             = d_rc_way_q;
  assign d_rc_wbuf_id         = d_rc_wbuf_q;
  assign d_rc_refill_data     = d_rc_data_q;
  assign crdt_avail           = crdt_avail_q;

endmodule

// File: tb/tb_isu_rc_arbiter.sv
// Directed bench for isu_rc_arbiter with CRDT_INIT=2; refill expectations follow ISU_ARB_REFILL_PRIO_EN.
module tb_isu_rc_arbiter;
  import isu_rc_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int SW = 8;
  localparam int WW = 3;
  localparam int BW = 4;
  localparam int RW = 5;
  localparam int CI = 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*3-1:0]    req_ch, req_op;
  logic [N*RW-1:0]   req_rob;
  logic [N*SW-1:0]   req_set;
  logic [N*WW-1:0]   req_way;
  logic [N*BW-1:0]   req_wbuf;
  logic [N*128-1:0]  req_data;
  logic [2:0]        xbar_rtn, crdt_avail;
  logic              d_rc_valid, d_rc_ready;
  logic [IW-1:0]     d_rc_req_id;
  logic [2:0]        d_rc_ch, d_rc_op;
  logic [RW-1:0]     d_rc_rob;
  logic [SW-1:0]     d_rc_set;
  logic [WW-1:0]     d_rc_way;
  logic [BW-1:0]     d_rc_wbuf;
  logic [127:0]      d_rc_data;

  int n_assert = 0;
  int n_fail   = 0;
  int grants;

  always #5 clk = ~clk;

  isu_rc_arbiter #(
    .NUM_REQ(N), .SET_W(SW), .WAY_W(WW), .WBUF_W(BW), .ROB_W(RW), .CRDT_INIT(CI)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_channel_1hot_id  (req_ch),
    .req_rob_id           (req_rob),
    .req_op               (req_op),
    .req_set              (req_set),
    .req_way              (req_way),
    .req_wbuf_id          (req_wbuf),
    .req_refill_data      (req_data),
    .xbar_crdt_rtn_valid  (xbar_rtn),
    .d_rc_valid           (d_rc_valid),
    .d_rc_ready           (d_rc_ready),
    .d_rc_req_id          (d_rc_req_id),
    .d_rc_channel_1hot_id (d_rc_ch),
    .d_rc_rob_id          (d_rc_rob),
    .d_rc_op              (d_rc_op),
    .d_rc_set             (d_rc_set),
    .d_rc_way             (d_rc_way),
    .d_rc_wbuf_id         (d_rc_wbuf),
    .d_rc_refill_data     (d_rc_data),
    .crdt_avail           (crdt_avail)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] ch, input logic [2:0] op);
    req_valid[i]            = v;
    req_ch[i*3 +: 3]        = ch;
    req_op[i*3 +: 3]        = op;
    req_set[i*SW +: SW]     = 8'(16 + i);
    req_way[i*WW +: WW]     = 3'(i);
    req_rob[i*RW +: RW]     = 5'(i + 5);
    req_wbuf[i*BW +: BW]    = 4'(i + 3);
    req_data[i*128 +: 128]  = {4{32'hA5A5_0000 + 32'(i)}};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_ch     = '0;
    req_op     = '0;
    req_rob    = '0;
    req_set    = '0;
    req_way    = '0;
    req_wbuf   = '0;
    req_data   = '0;
    xbar_rtn   = '0;
    d_rc_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_valid", d_rc_valid, 0);
    chk("rst_set", d_rc_set, 0);
    chk("rst_data", d_rc_data, 0);
    chk("rst_avail", crdt_avail, 3'b111);
    chk("rst_rr_ptr", dut.rr_ptr_q, 0);
    chk("rst_ready", req_ready, 0);

    // Round-robin over 4 queues on channel 0; a credit returns with each grant
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'b001, CACHE_OP_LOAD);
    xbar_rtn = 3'b001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", req_ready, 4'b0001 << (k % 4));
      tick();
      chk("rr_valid", d_rc_valid, 1);
      chk("rr_id", d_rc_req_id, k % 4);
      chk("rr_set", d_rc_set, 16 + (k % 4));
      chk("rr_rob", d_rc_rob, 5 + (k % 4));
    end
    req_valid = '0;
    xbar_rtn  = '0;
    chk("rr_data", d_rc_data, {4{32'hA5A5_0000}});
    chk("rr_way", d_rc_way, 0);
    chk("rr_wbuf", d_rc_wbuf, 3);
    chk("rr_ch", d_rc_ch, 3'b001);
    chk("rr_ptr_after", dut.rr_ptr_q, 1);
    tick();
    chk("rr_drain_valid", d_rc_valid, 0);
    chk("rr_cnt0", dut.crdt_cnt_q[0], 2);

    // Credit exhaustion on channel 1
    set_req(0, 1'b1, 3'b010, CACHE_OP_LOAD);
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (req_ready[0]) grants++;
      tick();
    end
    chk("exh_grants", grants, 2);
    chk("exh_avail", crdt_avail, 3'b101);
    chk("exh_ready", req_ready, 0);
    xbar_rtn = 3'b010;
    #1;
    chk("exh_rtn_no_comb", req_ready, 0);
    tick();
    xbar_rtn = '0;
    grants = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready[0]) grants++;
      tick();
    end
    chk("exh_regrant", grants, 1);
    chk("exh_cnt1", dut.crdt_cnt_q[1], 0);
    req_valid = '0;

    // Consume and return together at cnt=1
    xbar_rtn = 3'b010;
    tick();
    xbar_rtn = '0;
    chk("cr_cnt_before", dut.crdt_cnt_q[1], 1);
    set_req(1, 1'b1, 3'b010, CACHE_OP_LOAD);
    xbar_rtn = 3'b010;
    #1;
    chk("cr_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    xbar_rtn  = '0;
    chk("cr_cnt_after", dut.crdt_cnt_q[1], 1);
    chk("cr_avail", crdt_avail, 3'b111);
    chk("cr_id", d_rc_req_id, 1);
    tick();
    chk("cr_drain_valid", d_rc_valid, 0);

    // Backpressure: output holds, credits consumed once
    set_req(2, 1'b1, 3'b100, CACHE_OP_LOAD);
    d_rc_ready = 1'b0;
    #1;
    chk("bp_first_ready", req_ready, 4'b0100);
    tick();
    chk("bp_valid", d_rc_valid, 1);
    chk("bp_id", d_rc_req_id, 2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      tick();
      chk("bp_hold_valid", d_rc_valid, 1);
      chk("bp_hold_set", d_rc_set, 8'h12);
    end
    chk("bp_cnt2", dut.crdt_cnt_q[2], 1);

    // Reset while the output is stalled
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", d_rc_valid, 0);
    chk("mrst_cnt0", dut.crdt_cnt_q[0], CI);
    chk("mrst_cnt1", dut.crdt_cnt_q[1], CI);
    chk("mrst_cnt2", dut.crdt_cnt_q[2], CI);
    chk("mrst_rr_ptr", dut.rr_ptr_q, 0);
    chk("mrst_avail", crdt_avail, 3'b111);
    rst_n      = 1'b1;
    req_valid  = '0;
    d_rc_ready = 1'b1;
    tick();

    // Refill priority
    set_req(0, 1'b1, 3'b001, CACHE_OP_STORE);
    set_req(3, 1'b1, 3'b001, CACHE_OP_LOAD_REFILL);
    #1;
`ifdef ISU_ARB_REFILL_PRIO_EN
    chk("prio_ready", req_ready, 4'b1000);
    tick();
    chk("prio_id", d_rc_req_id, 3);
    chk("prio_op", d_rc_op, CACHE_OP_LOAD_REFILL);
`else
    chk("prio_ready", req_ready, 4'b0001);
    tick();
    chk("prio_id", d_rc_req_id, 0);
    chk("prio_op", d_rc_op, CACHE_OP_STORE);
`endif
    req_valid = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
